// File: rtl/gf2_poly_div_52bit.sv
`timescale 1ns/1ps
// Bit-serial GF(2)[x] long divider: dividend = quotient*divisor XOR remainder (carry-less).
// One quotient bit per cycle via a shift-left working register; invalid (non-monic) divisors flag err.
module gf2_poly_div_52bit #(
  parameter int N = 52
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2*N-2:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [N-1:0]     quotient,
  output logic [N-2:0]     remainder
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t          state;
  logic [2*N-2:0]  w;
  logic [N-1:0]    d;
  logic [CW-1:0]   count;
  logic [2*N-2:0]  w_xor;

  // The MSB of w always sits at the degree currently being eliminated.
  always_comb begin
    w_xor = w;
    if (w[2*N-2]) begin
      w_xor[2*N-2:N-1] = w[2*N-2:N-1] ^ d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      w         <= '0;
      d         <= '0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor[N-1]) begin
              w        <= dividend;
              d        <= divisor;
              quotient <= '0;
              err      <= 1'b0;
              count    <= '0;
              busy     <= 1'b1;
              state    <= RUN;
            end else begin
              quotient  <= '0;
              remainder <= '0;
              err       <= 1'b1;
              state     <= FIN;
            end
          end
        end
        RUN: begin
          quotient <= {quotient[N-2:0], w[2*N-2]};
          w        <= {w_xor[2*N-3:0], 1'b0};
          count    <= count + 1'b1;
          // After the last step the remainder occupies the bits just below the MSB.
          if (count == CW'(N-1)) begin
            remainder <= w_xor[2*N-3:N-1];
            busy      <= 1'b0;
            state     <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_poly_div_52bit.sv
`timescale 1ns/1ps
// Scoreboard bench for gf2_poly_div_52bit: directed cases, protocol cases and
// randomized round trips built from a carry-less multiply model.
module tb_gf2_poly_div_52bit;

  localparam int N = 52;

  typedef struct {
    logic [N-1:0] q;
    logic [N-2:0] r;
    logic         e;
    int           t0;
    int           lat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2*N-2:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic           busy, done, err;
  logic [N-1:0]   quotient;
  logic [N-2:0]   remainder;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   cyc = 0;

  gf2_poly_div_52bit #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .err(err), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2*N-2:0] clmul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-2:0] acc = '0;
    for (int i = 0; i < N; i++)
      if (b[i]) acc ^= ({{(N-1){1'b0}}, a} << i);
    return acc;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL spurious_done: got done=1 expected no pending operation (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 128'(quotient), 128'(e.q));
        check("remainder", 128'(remainder), 128'(e.r));
        check("err", 128'(err), 128'(e.e));
        check("busy_at_done", 128'(busy), 128'(0));
        check("latency", 128'(cyc - e.t0), 128'(e.lat));
      end
    end
  end

  task automatic wait_done(input int target, input string name);
    for (int i = 0; i < 400 && done_cnt < target; i++) begin
      @(negedge clk);
      #1;
    end
    if (done_cnt < target) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: got %0d done pulses expected %0d", name, done_cnt, target);
    end
  endtask

  // Issues one operation; glitch>0 pulses start with junk operands mid-run.
  task automatic applyStimulus(input logic [2*N-2:0] dvd, input logic [N-1:0] dvs,
                               input logic [N-1:0] eq, input logic [N-2:0] er,
                               input logic ee, input int glitch);
    exp_t e;
    int target;
    @(negedge clk);
    e.q = eq; e.r = er; e.e = ee; e.t0 = cyc; e.lat = ee ? 2 : N + 2;
    start = 1'b1; dividend = dvd; divisor = dvs;
    sb.push_back(e);
    target = done_cnt + 1;
    @(negedge clk);
    start = 1'b0;
    dividend = (2*N-1)'(rand128());
    divisor = N'(rand128());
    for (int i = 0; i < 400 && done_cnt < target; i++) begin
      start = (glitch > 0 && i == glitch) ? 1'b1 : 1'b0;
      @(negedge clk);
      #1;
    end
    start = 1'b0;
    wait_done(target, "op");
  endtask

  task automatic checkOutput(input string name);
    check({name, "_busy"}, 128'(busy), 128'(0));
    check({name, "_done"}, 128'(done), 128'(0));
    check({name, "_err"}, 128'(err), 128'(0));
    check({name, "_quotient"}, 128'(quotient), 128'(0));
    check({name, "_remainder"}, 128'(remainder), 128'(0));
  endtask

  initial begin
    logic [2*N-2:0] x102;
    logic [N-1:0]   a, b, xp1;
    logic [N-2:0]   r;
    int             c, target;

    x102 = '0; x102[2*N-2] = 1'b1;
    xp1 = '0; xp1[N-1] = 1'b1; xp1[0] = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(x102 | 103'd1, xp1, xp1, '0, 1'b0, 0);
    applyStimulus(x102 | 103'd5, xp1, xp1, 51'h4, 1'b0, 0);
    applyStimulus('0, 52'h8_0000_0000_0000, '0, '0, 1'b0, 0);
    applyStimulus((2*N-1)'(rand128()), 52'h7_FFFF_FFFF_FFFF, '0, '0, 1'b1, 0);

    // Abort mid-division: no done, everything back to zero.
    @(negedge clk);
    start = 1'b1; dividend = x102 | 103'd5; divisor = xp1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(negedge clk);
    applyStimulus(x102 | 103'd1, xp1, xp1, '0, 1'b0, 0);

    // Start held high across three operations.
    a = N'(rand128()); b = N'(rand128()) | 52'h8_0000_0000_0000; r = (N-1)'(rand128());
    @(negedge clk);
    c = cyc;
    start = 1'b1; dividend = clmul(a, b) ^ {{N{1'b0}}, r}; divisor = b;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.q = a; e.r = r; e.e = 1'b0; e.t0 = c + k * (N + 2); e.lat = N + 2;
      sb.push_back(e);
    end
    target = done_cnt + 3;
    repeat (2 * (N + 2) + 1) @(negedge clk);
    start = 1'b0;
    wait_done(target, "held_start");
    repeat (N + 10) @(negedge clk);

    // Start pulsed during RUN must be ignored.
    a = N'(rand128()); b = N'(rand128()) | 52'h8_0000_0000_0000; r = (N-1)'(rand128());
    applyStimulus(clmul(a, b) ^ {{N{1'b0}}, r}, b, a, r, 1'b0, 10);

    for (int n = 0; n < 250; n++) begin
      a = N'(rand128()); b = N'(rand128()) | 52'h8_0000_0000_0000; r = (N-1)'(rand128());
      if (n % 50 == 7) begin
        b[N-1] = 1'b0;
        applyStimulus(clmul(a, b), b, '0, '0, 1'b1, 0);
      end else begin
        applyStimulus(clmul(a, b) ^ {{N{1'b0}}, r}, b, a, r, 1'b0, 0);
      end
    end

    repeat (5) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL pending: got %0d unfinished operations expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
